uparc_dbus_arb: RTL and testbench

//  Two-master arbiter sharing one D-Bus slave port. M0 is the CPU load-store unit; M1 is a secondary master (debug/DMA).

---
 rtl/uparc_dbus_arb.sv | 113 +++++++++++
 tb/tb_uparc_dbus_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uparc_dbus_arb.sv
// Two-master D-Bus arbiter: grants one transfer at a time to a shared slave,
// routes the response back to its owner, with an optional WAIT watchdog.
module uparc_dbus_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4,
    parameter int RR         = 1,
    parameter int TMO_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_M0Addr,
    input  logic                  i_M0Cmd,
    input  logic                  i_M0RnW,
    input  logic [BEN_WIDTH-1:0]  i_M0Ben,
    input  logic [DATA_WIDTH-1:0] i_M0Data,
    output logic                  o_M0Rdy,
    output logic                  o_M0Err,
    input  logic [ADDR_WIDTH-1:0] i_M1Addr,
    input  logic                  i_M1Cmd,
    input  logic                  i_M1RnW,
    input  logic [BEN_WIDTH-1:0]  i_M1Ben,
    input  logic [DATA_WIDTH-1:0] i_M1Data,
    output logic                  o_M1Rdy,
    output logic                  o_M1Err,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [ADDR_WIDTH-1:0] o_DAddr,
    output logic                  o_DCmd,
    output logic                  o_DRnW,
    output logic [BEN_WIDTH-1:0]  o_DBen,
    output logic [DATA_WIDTH-1:0] o_DData,
    input  logic [DATA_WIDTH-1:0] i_DData,
    input  logic                  i_DRdy,
    input  logic                  i_DErr
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
    localparam bit          TMO_EN   = (TMO_CYCLES != 0);

    state_t      state_q, state_d;
    logic        own_q, own_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;

    logic winner, busy, issue, active, sel, rsp, tmo, rdy, err;

    always_comb begin
        winner = 1'b0;
        if (i_M0Cmd && i_M1Cmd)
            winner = (RR != 0) ? ~last_q : 1'b0;
        else if (i_M1Cmd)
            winner = 1'b1;

        busy   = (state_q == WAIT);
        issue  = nrst && !busy && (i_M0Cmd || i_M1Cmd);
        active = busy || issue;
        sel    = busy ? own_q : winner;
        rsp    = active && (i_DRdy || i_DErr);
        // Watchdog fires only when the slave stays silent on the last allowed cycle
        tmo    = TMO_EN && busy && !rsp && (cnt_q == TMO_LAST);
        rdy    = active && i_DRdy;
        err    = (active && i_DErr) || tmo;

        o_M0Rdy = rdy && !sel;
        o_M0Err = err && !sel;
        o_M1Rdy = rdy && sel;
        o_M1Err = err && sel;
        o_MData = i_DData;
        o_DCmd  = issue;
        o_DAddr = !active ? '0 : (sel ? i_M1Addr : i_M0Addr);
        o_DRnW  = active && (sel ? i_M1RnW : i_M0RnW);
        o_DBen  = !active ? '0 : (sel ? i_M1Ben : i_M0Ben);
        o_DData = !active ? '0 : (sel ? i_M1Data : i_M0Data);

        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (issue) begin
            if (rsp) begin
                last_d = winner;
            end else begin
                own_d   = winner;
                cnt_d   = '0;
                state_d = WAIT;
            end
        end else if (busy) begin
            if (rsp || tmo) begin
                last_d  = own_q;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uparc_dbus_arb.sv
// Directed bench for uparc_dbus_arb: a round-robin instance with a 4-cycle
// watchdog and a fixed-priority instance without watchdog share all inputs.
module tb_uparc_dbus_arb;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] m0_addr, m1_addr, m0_data, m1_data, d_rdata;
    logic        m0_cmd, m1_cmd, m0_rnw, m1_rnw, d_rdy, d_err;
    logic [3:0]  m0_ben, m1_ben;

    logic        m0_rdy, m0_err, m1_rdy, m1_err, d_cmd, d_rnw;
    logic [31:0] m_data, d_addr, d_wdata;
    logic [3:0]  d_ben;

    logic        f_m0_rdy, f_m0_err, f_m1_rdy, f_m1_err, f_d_cmd, f_d_rnw;
    logic [31:0] f_m_data, f_d_addr, f_d_wdata;
    logic [3:0]  f_d_ben;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uparc_dbus_arb #(.RR(1), .TMO_CYCLES(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_M0Addr(m0_addr), .i_M0Cmd(m0_cmd), .i_M0RnW(m0_rnw),
        .i_M0Ben(m0_ben), .i_M0Data(m0_data),
        .o_M0Rdy(m0_rdy), .o_M0Err(m0_err),
        .i_M1Addr(m1_addr), .i_M1Cmd(m1_cmd), .i_M1RnW(m1_rnw),
        .i_M1Ben(m1_ben), .i_M1Data(m1_data),
        .o_M1Rdy(m1_rdy), .o_M1Err(m1_err),
        .o_MData(m_data), .o_DAddr(d_addr), .o_DCmd(d_cmd),
        .o_DRnW(d_rnw), .o_DBen(d_ben), .o_DData(d_wdata),
        .i_DData(d_rdata), .i_DRdy(d_rdy), .i_DErr(d_err)
    );

    uparc_dbus_arb #(.RR(0), .TMO_CYCLES(0)) fp (
        .clk(clk), .nrst(nrst),
        .i_M0Addr(m0_addr), .i_M0Cmd(m0_cmd), .i_M0RnW(m0_rnw),
        .i_M0Ben(m0_ben), .i_M0Data(m0_data),
        .o_M0Rdy(f_m0_rdy), .o_M0Err(f_m0_err),
        .i_M1Addr(m1_addr), .i_M1Cmd(m1_cmd), .i_M1RnW(m1_rnw),
        .i_M1Ben(m1_ben), .i_M1Data(m1_data),
        .o_M1Rdy(f_m1_rdy), .o_M1Err(f_m1_err),
        .o_MData(f_m_data), .o_DAddr(f_d_addr), .o_DCmd(f_d_cmd),
        .o_DRnW(f_d_rnw), .o_DBen(f_d_ben), .o_DData(f_d_wdata),
        .i_DData(d_rdata), .i_DRdy(d_rdy), .i_DErr(d_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cmd = 0; m1_cmd = 0; d_rdy = 0; d_err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
    endtask

    initial begin
        m0_addr = 0; m1_addr = 0; m0_data = 0; m1_data = 0; d_rdata = 0;
        m0_rnw = 0; m1_rnw = 0; m0_ben = 0; m1_ben = 0;
        idle_inputs();
        nrst = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_dcmd", d_cmd, 0);
        chk("rst_daddr", d_addr, 0);
        chk("rst_m0rdy", m0_rdy, 0);
        nrst = 1'b1;
        tick();

        // zero-wait M0 read
        m0_cmd = 1; m0_rnw = 1; m0_addr = 32'h100; m0_ben = 4'hF;
        d_rdy = 1; d_rdata = 32'hDEADBEEF;
        #1;
        chk("zw_dcmd", d_cmd, 1);
        chk("zw_daddr", d_addr, 32'h100);
        chk("zw_m0rdy", m0_rdy, 1);
        chk("zw_mdata", m_data, 32'hDEADBEEF);
        chk("zw_m1rdy", m1_rdy, 0);
        tick();
        idle_inputs();
        #1;
        chk("zw_dcmd_off", d_cmd, 0);
        chk("idle_drdy_drop", m0_rdy, 0);

        // round-robin tie, 2-cycle slave latency
        do_reset();
        m0_cmd = 1; m0_addr = 32'h100; m0_rnw = 1;
        m1_cmd = 1; m1_addr = 32'h200; m1_rnw = 0;
        #1;
        chk("rr_iss0_dcmd", d_cmd, 1);
        chk("rr_iss0_addr", d_addr, 32'h100);
        chk("rr_iss0_m0rdy", m0_rdy, 0);
        tick();
        #1;
        chk("rr_w1_dcmd", d_cmd, 0);
        chk("rr_w1_addr", d_addr, 32'h100);
        tick();
        d_rdy = 1;
        #1;
        chk("rr_done0_m0rdy", m0_rdy, 1);
        chk("rr_done0_m1rdy", m1_rdy, 0);
        tick();
        d_rdy = 0;
        #1;
        chk("rr_iss1_dcmd", d_cmd, 1);
        chk("rr_iss1_addr", d_addr, 32'h200);
        chk("rr_iss1_rnw", d_rnw, 0);
        tick();
        tick();
        d_rdy = 1;
        #1;
        chk("rr_done1_m1rdy", m1_rdy, 1);
        chk("rr_done1_m0rdy", m0_rdy, 0);
        tick();
        #1;
        chk("rr_tie2_addr", d_addr, 32'h100);
        chk("rr_tie2_m0rdy", m0_rdy, 1);
        tick();
        idle_inputs();

        // fixed priority starves M1
        do_reset();
        m0_cmd = 1; m0_addr = 32'h300; m1_cmd = 1; m1_addr = 32'h400;
        d_rdy = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fp_m0rdy", f_m0_rdy, 1);
            chk("fp_m1rdy", f_m1_rdy, 0);
            chk("fp_addr", f_d_addr, 32'h300);
            tick();
        end
        idle_inputs();

        // watchdog: silent slave, M1 read
        do_reset();
        m1_cmd = 1; m1_rnw = 1; m1_addr = 32'h500;
        #1;
        chk("tmo_iss_dcmd", d_cmd, 1);
        chk("tmo_iss_m1err", m1_err, 0);
        tick();
        m1_cmd = 0;
        for (int w = 1; w <= 3; w++) begin
            #1;
            chk("tmo_wait_m1err", m1_err, 0);
            tick();
        end
        #1;
        chk("tmo_w4_m1err", m1_err, 1);
        chk("tmo_w4_m1rdy", m1_rdy, 0);
        tick();
        d_rdy = 1;
        #1;
        chk("tmo_late_m1rdy", m1_rdy, 0);
        chk("tmo_late_m1err", m1_err, 0);
        tick();
        m0_cmd = 1; m0_addr = 32'h100;
        #1;
        chk("tmo_idle_dcmd", d_cmd, 1);
        chk("tmo_idle_m0rdy", m0_rdy, 1);
        tick();
        idle_inputs();

        // M1 write terminated by slave error
        do_reset();
        m1_cmd = 1; m1_rnw = 0; m1_addr = 32'h600;
        m1_ben = 4'b1100; m1_data = 32'hABCD0000;
        #1;
        chk("err_iss_dcmd", d_cmd, 1);
        chk("err_iss_ben", d_ben, 4'b1100);
        chk("err_iss_data", d_wdata, 32'hABCD0000);
        tick();
        m1_cmd = 0;
        #1;
        chk("err_w1_ben", d_ben, 4'b1100);
        chk("err_w1_m1err", m1_err, 0);
        tick();
        d_err = 1;
        #1;
        chk("err_w2_m1err", m1_err, 1);
        chk("err_w2_m1rdy", m1_rdy, 0);
        chk("err_w2_m0err", m0_err, 0);
        chk("err_w2_m0rdy", m0_rdy, 0);
        chk("err_w2_ben", d_ben, 4'b1100);
        tick();
        idle_inputs();

        // reset in the middle of a WAIT
        do_reset();
        m0_cmd = 1; m0_addr = 32'h700;
        tick();
        #1;
        chk("mr_wait_addr", d_addr, 32'h700);
        nrst = 1'b0;
        #1;
        chk("mr_dcmd", d_cmd, 0);
        chk("mr_daddr", d_addr, 0);
        chk("mr_m0rdy", m0_rdy, 0);
        m0_cmd = 0;
        tick();
        nrst = 1'b1;
        d_rdy = 1;
        #1;
        chk("mr_late_m0rdy", m0_rdy, 0);
        chk("mr_late_m1rdy", m1_rdy, 0);
        tick();
        d_rdy = 0;
        m0_cmd = 1; m0_addr = 32'h100; m1_cmd = 1; m1_addr = 32'h200;
        #1;
        chk("mr_tie_addr", d_addr, 32'h100);
        tick();
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
